// File: rtl/scroll_sequencer.sv
// rtl/scroll_sequencer.sv - scrolls a message across a column-multiplexed LED panel
//
// Fetches NUM_COLS columns from an external combinational column mux into a
// back buffer, swaps the back buffer into the front buffer once per scroll
// step, and scans the front buffer onto the panel one column at a time.
//
// Ports:
//   CLK         system clock
//   RST         synchronous active-high reset
//   EN          run/pause for scrolling; the panel scan runs regardless
//   RESTART     one-cycle pulse, returns the scroll to offset 0
//   D_IN        column data from the mux for the current SEL (same cycle)
//   SEL         column index to the mux
//   COL_EN      one-hot active-high panel column enable
//   ROW_DATA    row data for the enabled column, 7'h7F = all off
//   OFFSET      current scroll offset
//   FRAME_SWAP  one-cycle pulse on each back-to-front buffer swap

module scroll_sequencer #(
  parameter int NUM_COLS   = 24,
  parameter int MSG_LEN    = 72,
  parameter int STEP_TICKS = 5000000,
  parameter int SCAN_TICKS = 1000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                RESTART,
  input  logic [6:0]          D_IN,
  output logic [6:0]          SEL,
  output logic [NUM_COLS-1:0] COL_EN,
  output logic [6:0]          ROW_DATA,
  output logic [6:0]          OFFSET,
  output logic                FRAME_SWAP
);

  localparam int IDX_W  = (NUM_COLS > 1)   ? $clog2(NUM_COLS)   : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_COLS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
  localparam logic [6:0]        OFF_LAST  = 7'(MSG_LEN - 1);
  localparam logic [7:0]        MSG_LEN_8 = 8'(MSG_LEN);
  localparam logic [6:0]        BLANK     = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  col;
  logic [STEP_W-1:0] step_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [6:0]        offset;
  logic              pending;
  logic [6:0]        back_buf  [NUM_COLS];
  logic [6:0]        front_buf [NUM_COLS];

  logic       fetch_wr;
  logic       swap;
  logic       step_tc;
  logic [7:0] sum;

  // Message index for the column being fetched, wrapped into 0..MSG_LEN-1.
  // The sum is 8 bits so offset+idx up to 126+127 cannot overflow.
  assign sum = {1'b0, offset} + 8'(idx);
  assign SEL = (sum >= MSG_LEN_8) ? 7'(sum - MSG_LEN_8) : 7'(sum);

  assign step_tc  = EN && (step_cnt == STEP_LAST);
  assign OFFSET   = offset;
  assign COL_EN   = NUM_COLS'(1) << col;
  assign ROW_DATA = front_buf[col];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (RESTART) begin
      state_nxt = EN ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (EN) state_nxt = S_FETCH;
        S_FETCH: if (EN && (idx == IDX_LAST)) state_nxt = S_WAIT;
        S_WAIT:  if (EN && pending) state_nxt = S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs; RESTART suppresses both the fetch write and the swap
  always_comb begin
    fetch_wr   = 1'b0;
    swap       = 1'b0;
    FRAME_SWAP = 1'b0;
    if (!RST && !RESTART) begin
      fetch_wr   = (state == S_FETCH) && EN;
      swap       = (state == S_WAIT) && EN && pending;
      FRAME_SWAP = swap;
    end
  end

  // Scroll datapath: fetch index, step timer, buffers and offset
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx      <= '0;
      offset   <= '0;
      step_cnt <= '0;
      pending  <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        back_buf[i]  <= BLANK;
        front_buf[i] <= BLANK;
      end
    end else if (RESTART) begin
      idx      <= '0;
      offset   <= '0;
      step_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (EN) begin
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
      end

      // A terminal count on the swap edge wins, so the next step is not lost.
      if (step_tc) begin
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end

      if ((state == S_IDLE) && EN) begin
        idx <= '0;
      end

      if (fetch_wr) begin
        back_buf[idx] <= D_IN;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      if (swap) begin
        for (int i = 0; i < NUM_COLS; i++) begin
          front_buf[i] <= back_buf[i];
        end
        offset <= (offset == OFF_LAST) ? '0 : offset + 7'd1;
      end
    end
  end

  // Panel column scan, free-running regardless of EN, state and RESTART
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= '0;
      col      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      col      <= (col == IDX_LAST) ? '0 : col + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb/tb_scroll_sequencer.sv - scoreboard bench for scroll_sequencer

module tb_scroll_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        restart;
  logic [6:0]  sel;
  logic [23:0] col_en;
  logic [6:0]  row_data;
  logic [6:0]  offset;
  logic        frame_swap;

  logic        en_s;
  logic        restart_s;
  logic [6:0]  sel_s;
  logic [23:0] col_en_s;
  logic [6:0]  row_data_s;
  logic [6:0]  off_s;
  logic        fs_s;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int mark     = 0;

  logic [6:0] swap_q[$];

  int col_m       = 0;
  int cnt_m       = 0;
  int front_base  = 0;
  bit front_valid = 0;
  bit post_pend   = 0;
  int post_exp    = 0;
  int short_swaps = 0;

  scroll_sequencer #(
    .NUM_COLS(24), .MSG_LEN(72), .STEP_TICKS(40), .SCAN_TICKS(4)
  ) u_dut (
    .CLK(clk), .RST(rst), .EN(en), .RESTART(restart), .D_IN(sel),
    .SEL(sel), .COL_EN(col_en), .ROW_DATA(row_data), .OFFSET(offset),
    .FRAME_SWAP(frame_swap)
  );

  scroll_sequencer #(
    .NUM_COLS(24), .MSG_LEN(72), .STEP_TICKS(10), .SCAN_TICKS(4)
  ) u_short (
    .CLK(clk), .RST(rst), .EN(en_s), .RESTART(restart_s), .D_IN(sel_s),
    .SEL(sel_s), .COL_EN(col_en_s), .ROW_DATA(row_data_s), .OFFSET(off_s),
    .FRAME_SWAP(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Expected panel column: advances every 4 cycles, wraps after 23
  always @(posedge clk) begin
    if (rst) begin
      col_m = 0;
      cnt_m = 0;
    end else if (cnt_m == 3) begin
      cnt_m = 0;
      col_m = (col_m == 23) ? 0 : col_m + 1;
    end else begin
      cnt_m = cnt_m + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue the expected pre-swap offset, then wait for the pulse and check its
  // distance in clock edges from the last reference point.
  task automatic wait_swap(input logic [6:0] exp_off, input int exp_gap);
    int n;
    n = 0;
    swap_q.push_back(exp_off);
    do begin
      @(negedge clk);
      n++;
    end while (frame_swap !== 1'b1 && n < 400);
    if (frame_swap !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL swap_timeout: no FRAME_SWAP for offset %0d within 400 cycles", exp_off);
    end else begin
      chk("swap_gap", cyc - mark, exp_gap);
    end
    mark = cyc;
  endtask

  // Scoreboard monitor for the main instance
  initial begin
    logic [6:0] e;
    logic [6:0] exp_row;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst) front_valid = 0;
        if (post_pend) begin
          chk("offset_after_swap", offset, post_exp);
          chk("swap_single_cycle", frame_swap, 0);
          post_pend = 0;
        end
        chk("col_en", col_en, 32'h1 << col_m);
        exp_row = front_valid ? 7'((front_base + col_m) % 72) : 7'h7F;
        chk("row_data", row_data, exp_row);
        if (frame_swap === 1'b1) begin
          if (swap_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_swap: FRAME_SWAP at OFFSET=%0d, none required", offset);
          end else begin
            e = swap_q.pop_front();
            chk("offset_at_swap", offset, e);
            post_exp    = (e == 71) ? 0 : e + 1;
            post_pend   = 1;
            front_base  = e;
            front_valid = 1;
          end
        end
      end
    end
  end

  // Short-step instance: every swap follows the back[23] write by one cycle
  initial begin
    bit pm;
    pm = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0 && !rst) begin
        if (pm || fs_s) chk("short_swap_after_last_write", fs_s, pm);
        if (fs_s) short_swaps++;
      end
      pm = (sel_s == 7'((off_s + 23) % 72));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    restart   = 1'b0;
    en_s      = 1'b1;
    restart_s = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sel", sel, 0);
    chk("reset_col_en", col_en, 24'h000001);
    chk("reset_row_data", row_data, 7'h7F);
    chk("reset_offset", offset, 0);
    chk("reset_frame_swap", frame_swap, 0);
    rst  = 1'b0;
    mark = cyc;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fetch0_sel", sel, i);
    end
    wait_swap(7'd0, 40);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fetch1_sel", sel, i + 1);
    end
    wait_swap(7'd1, 40);
    wait_swap(7'd2, 40);

    // Pause at idx 10 of the offset-3 fetch
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("pause_sel_idx10", sel, 13);
    en = 1'b0;
    begin
      logic [23:0] ce_prev;
      int changes;
      ce_prev = col_en;
      changes = 0;
      for (int j = 0; j < 20; j++) begin
        @(posedge clk);
        @(negedge clk);
        chk("pause_sel_hold", sel, 13);
        if (col_en !== ce_prev) changes++;
        ce_prev = col_en;
      end
      chk("pause_scan_rotations", changes, 5);
    end
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("resume_sel", sel, 14);
    wait_swap(7'd3, 60);
    wait_swap(7'd4, 40);

    // RESTART while waiting at offset 5
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("pre_restart_offset", offset, 5);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    mark    = cyc;
    chk("restart_offset", offset, 0);
    chk("restart_sel", sel, 0);
    chk("restart_old_frame", row_data, 7'((4 + col_m) % 72));
    for (int i = 1; i < 24; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("restart_fetch_sel", sel, i);
    end
    wait_swap(7'd0, 40);

    // Run through the wrap of both SEL and OFFSET
    for (int o = 1; o <= 71; o++) begin
      wait_swap(7'(o), 40);
      if (o == 59) begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk);
          @(negedge clk);
          chk("wrap_fetch_sel", sel, (60 + i) % 72);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("wrap_offset_zero", offset, 0);

    chk("short_swaps_seen", (short_swaps >= 100) ? 1 : 0, 1);
    chk("scoreboard_drained", swap_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
